// File: rtl/strobe_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : strobe_meter_pkg
// Purpose  : Shared types and helpers for the strobe period meter.
//            - state_t  : measurement FSM states (IDLE, MEASURE)
//            - calc_pw  : width needed to hold a period of up to MAX_PERIOD
// Revision : 1.0 - initial release
// ============================================================================
package strobe_meter_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   // A period can equal MAX_PERIOD itself, hence the +1.
   function automatic int calc_pw(input int max_period);
      return $clog2(max_period + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/strobe_meter_lock.sv
`default_nettype none
// ============================================================================
// Module   : strobe_meter_lock
// Purpose  : Period-stability detector. Compares every measurement with the
//            previous one and asserts locked after LOCK_COUNT consecutive
//            measurements that agree within TOL.
// Ports    : clk      - clock
//            reset_n  - synchronous active-low reset
//            meas     - one-cycle pulse, period is a new measurement
//            period   - measured period
//            clear    - forget history (next measurement is a first one)
//            locked   - level, period is stable
// Revision : 1.0 - initial release
// ============================================================================
module strobe_meter_lock #(
   parameter int PW         = 11,
   parameter int LOCK_COUNT = 4,
   parameter int TOL        = 0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          meas,
   input  logic [PW-1:0] period,
   input  logic          clear,
   output logic          locked
);

   localparam int            MW     = (LOCK_COUNT > 2) ? $clog2(LOCK_COUNT) : 1;
   localparam logic [MW-1:0] MC_MAX = MW'(LOCK_COUNT - 1);
   localparam logic [PW-1:0] TOL_W  = PW'(TOL);

   logic [PW-1:0] prev;
   logic [MW-1:0] match_cnt;
   logic          have_prev;   // prev holds a real measurement

   logic [PW-1:0] diff;
   logic          is_match;
   logic [MW-1:0] match_cnt_next;

   // Absolute difference without wrap: subtract the smaller from the larger.
   always_comb begin
      diff           = (period >= prev) ? (period - prev) : (prev - period);
      is_match       = (diff <= TOL_W);
      match_cnt_next = (match_cnt == MC_MAX) ? match_cnt : match_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         prev      <= '0;
         match_cnt <= '0;
         have_prev <= 1'b0;
         locked    <= 1'b0;
      end else if (meas) begin
         prev      <= period;
         have_prev <= 1'b1;
         // The first measurement after idle only seeds prev.
         if (have_prev) begin
            if (is_match) begin
               match_cnt <= match_cnt_next;
               locked    <= (match_cnt_next == MC_MAX);
            end else begin
               match_cnt <= '0;
               locked    <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/strobe_meter.sv
`default_nettype none
// ============================================================================
// Module   : strobe_meter
// Purpose  : Measures the cycle count between consecutive single-cycle
//            strobes, reports each period with a valid pulse, declares lock
//            on a stable period and flags timeout when strobes stop.
// Ports    : i_clk        - clock
//            i_reset_n    - synchronous active-low reset
//            i_strobe     - strobe, every high cycle is one event
//            o_period     - last measured period (held)
//            o_valid      - one-cycle pulse, o_period just updated
//            o_locked     - level, period is stable
//            o_timeout    - level, no strobe within MAX_PERIOD cycles
//            i_stats_clr  - (STROBE_METER_STATS_EN) clear min/max
//            o_min_period - (STROBE_METER_STATS_EN) smallest period seen
//            o_max_period - (STROBE_METER_STATS_EN) largest period seen
// Options  : STROBE_METER_STATS_EN - adds min/max period statistics
// Revision : 1.0 - initial release
// ============================================================================
module strobe_meter
   import strobe_meter_pkg::*;
#(
   parameter  int MAX_PERIOD = 1024,
   parameter  int LOCK_COUNT = 4,
   parameter  int TOL        = 0,
   localparam int PW         = calc_pw(MAX_PERIOD)
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_strobe,
`ifdef STROBE_METER_STATS_EN
   input  logic          i_stats_clr,
   output logic [PW-1:0] o_min_period,
   output logic [PW-1:0] o_max_period,
`endif
   output logic [PW-1:0] o_period,
   output logic          o_valid,
   output logic          o_locked,
   output logic          o_timeout
);

   generate
      if (MAX_PERIOD < 2) begin : g_bad_max_period
         $error("strobe_meter: MAX_PERIOD must be >= 2");
      end
      if (LOCK_COUNT < 2) begin : g_bad_lock_count
         $error("strobe_meter: LOCK_COUNT must be >= 2");
      end
      if (TOL >= MAX_PERIOD) begin : g_bad_tol
         $error("strobe_meter: TOL must be < MAX_PERIOD");
      end
   endgenerate

   localparam logic [PW-1:0] CNT_LAST = PW'(MAX_PERIOD - 1);

   state_t        state;
   state_t        state_next;
   logic [PW-1:0] cnt;
   logic [PW-1:0] cnt_next;
   logic          meas;        // strobe sampled in MEASURE
   logic          tmo_hit;     // counter expired without a strobe
   logic [PW-1:0] meas_period;

   assign meas_period = cnt + 1'b1;

   // Next-state and counter logic. A strobe on the last count wins over
   // the timeout, giving a valid period of MAX_PERIOD.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      meas       = 1'b0;
      tmo_hit    = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (i_strobe) begin
               state_next = MEASURE;
            end
         end
         MEASURE: begin
            if (i_strobe) begin
               meas     = 1'b1;
               cnt_next = '0;
            end else if (cnt == CNT_LAST) begin
               tmo_hit    = 1'b1;
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         cnt       <= '0;
         o_period  <= '0;
         o_valid   <= 1'b0;
         o_timeout <= 1'b0;
      end else begin
         cnt     <= cnt_next;
         o_valid <= meas;
         if (meas) begin
            o_period <= meas_period;
         end
         if (tmo_hit) begin
            o_timeout <= 1'b1;
         end else if (i_strobe) begin
            o_timeout <= 1'b0;
         end
      end
   end

   strobe_meter_lock #(
      .PW         (PW),
      .LOCK_COUNT (LOCK_COUNT),
      .TOL        (TOL)
   ) u_lock (
      .clk     (i_clk),
      .reset_n (i_reset_n),
      .meas    (meas),
      .period  (meas_period),
      .clear   (tmo_hit),
      .locked  (o_locked)
   );

`ifdef STROBE_METER_STATS_EN
   // Clear takes priority; a coinciding measurement is not folded in.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n || i_stats_clr) begin
         o_min_period <= '1;
         o_max_period <= '0;
      end else if (meas) begin
         if (meas_period < o_min_period) begin
            o_min_period <= meas_period;
         end
         if (meas_period > o_max_period) begin
            o_max_period <= meas_period;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_strobe_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_strobe_meter
// Purpose  : Self-checking bench for strobe_meter. A cycle-level model keyed
//            on strobe edge times predicts periods (scoreboard queue), lock
//            and timeout levels.
// Options  : STROBE_METER_STATS_EN - also checks min/max statistics
// Revision : 1.0 - initial release
// ============================================================================
module tb_strobe_meter;

   localparam int MAXP = 16;
   localparam int LC   = 4;
   localparam int PW   = $clog2(MAXP + 1);

   logic          clk = 1'b0;
   logic          i_reset_n = 1'b0;
   logic          i_strobe = 1'b0;
   logic [PW-1:0] o_period;
   logic          o_valid;
   logic          o_locked;
   logic          o_timeout;
`ifdef STROBE_METER_STATS_EN
   logic          i_stats_clr = 1'b0;
   logic [PW-1:0] o_min_period;
   logic [PW-1:0] o_max_period;
   int            m_min = (1 << PW) - 1;
   int            m_max = 0;
`endif

   always #5 clk = ~clk;

   strobe_meter #(
      .MAX_PERIOD (MAXP),
      .LOCK_COUNT (LC),
      .TOL        (0)
   ) dut (
      .i_clk        (clk),
      .i_reset_n    (i_reset_n),
      .i_strobe     (i_strobe),
`ifdef STROBE_METER_STATS_EN
      .i_stats_clr  (i_stats_clr),
      .o_min_period (o_min_period),
      .o_max_period (o_max_period),
`endif
      .o_period     (o_period),
      .o_valid      (o_valid),
      .o_locked     (o_locked),
      .o_timeout    (o_timeout)
   );

   int vecs = 0;
   int errs = 0;

   // Model state
   bit m_active = 1'b0;
   bit m_tmo    = 1'b0;
   bit m_locked = 1'b0;
   int m_period = 0;
   int m_edge   = 0;
   int m_last   = 0;
   int m_hist[$];
   int sb[$];

   task automatic check(input string tag, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s @edge %0d: got %0d, expected %0d", tag, m_edge, act, exp);
      end
   endtask

   // Locked when the last LC measurements since idle are all equal.
   function automatic bit calc_lock();
      int n;
      n = m_hist.size();
      if (n < LC) return 1'b0;
      for (int i = n - LC + 1; i < n; i++) begin
         if (m_hist[i] != m_hist[n-LC]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic step(input bit s, input bit rn);
      int p;
      bit measured;
      measured  = 1'b0;
      p         = 0;
      i_strobe  = s;
      i_reset_n = rn;
      @(posedge clk);
      m_edge++;
      if (!rn) begin
         m_active = 1'b0;
         m_tmo    = 1'b0;
         m_locked = 1'b0;
         m_period = 0;
         m_hist.delete();
         sb.delete();
      end else if (s) begin
         if (m_active) begin
            p        = m_edge - m_last;
            m_period = p;
            m_hist.push_back(p);
            m_locked = calc_lock();
            sb.push_back(p);
            measured = 1'b1;
         end
         m_active = 1'b1;
         m_tmo    = 1'b0;
         m_last   = m_edge;
      end else if (m_active && (m_edge - m_last == MAXP)) begin
         m_active = 1'b0;
         m_tmo    = 1'b1;
         m_locked = 1'b0;
         m_hist.delete();
      end
`ifdef STROBE_METER_STATS_EN
      if (!rn || i_stats_clr) begin
         m_min = (1 << PW) - 1;
         m_max = 0;
      end else if (measured) begin
         if (p < m_min) m_min = p;
         if (p > m_max) m_max = p;
      end
`endif
      #1;
      if (sb.size() > 0) begin
         check("valid", int'(o_valid), 1);
         check("period_on_valid", int'(o_period), sb.pop_front());
      end else begin
         check("valid", int'(o_valid), 0);
      end
      check("period", int'(o_period), m_period);
      check("locked", int'(o_locked), int'(m_locked));
      check("timeout", int'(o_timeout), int'(m_tmo));
`ifdef STROBE_METER_STATS_EN
      check("min", int'(o_min_period), m_min);
      check("max", int'(o_max_period), m_max);
`endif
   endtask

   task automatic strobe_every(input int n, input int count);
      for (int k = 0; k < count; k++) begin
         step(1'b1, 1'b1);
         for (int j = 0; j < n - 1; j++) step(1'b0, 1'b1);
      end
   endtask

   initial begin
      // Reset hold with strobe toggling
      for (int i = 0; i < 5; i++) step(i[0], 1'b0);

      // Period 10: lock on the 4th measurement, then 11s break and re-lock
      strobe_every(10, 6);
      strobe_every(11, 5);

      // Strobes stop: timeout after MAXP cycles
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

      // Restart: no valid, then strobes at the very last count
      step(1'b1, 1'b1);
      for (int i = 0; i < MAXP - 1; i++) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      for (int i = 0; i < MAXP - 1; i++) step(1'b0, 1'b1);
      step(1'b1, 1'b1);

      // Constant strobe: period 1 every cycle
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1);

`ifdef STROBE_METER_STATS_EN
      // Clear coinciding with a measurement drops that measurement
      i_stats_clr = 1'b1;
      step(1'b1, 1'b1);
      i_stats_clr = 1'b0;
      strobe_every(2, 2);
`endif

      // Reset while locked mid-measurement, then restart
      strobe_every(5, 5);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      strobe_every(3, 3);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/strobe_meter.md
Name: strobe_meter

Overview:
- Receiving end of the strobe interface: consumes a single-cycle strobe train, e.g. from the team's strobe divider or an external tick source.
- Measures the cycle count between consecutive strobes and reports each period with a valid pulse.
- Declares lock when the period is stable and flags timeout when strobes stop.
- Used for tick sanity checking, baud/rate detection and clock-ratio monitoring.

Parameters:
- MAX_PERIOD, 1024, longest measurable period in i_clk cycles; must be >= 2 (elaboration $error otherwise).
- LOCK_COUNT, 4, consecutive matching measurements required for lock; must be >= 2.
- TOL, 0, allowed absolute difference, in cycles, between successive periods that still counts as a match; must be < MAX_PERIOD.

Ports:
- i_clk  input  1  clock.
- i_reset_n  input  1  synchronous active-low reset.
- i_strobe  input  1  strobe; every cycle sampled high is one strobe event.
- o_period  output  PW=$clog2(MAX_PERIOD+1)  last measured period, held between updates.
- o_valid  output  1  one-cycle pulse: o_period has just been updated.
- o_locked  output  1  level: period is stable.
- o_timeout  output  1  level: no strobe within MAX_PERIOD cycles; cleared by the next strobe.

Behaviour:
- Clock is i_clk. Reset is synchronous, active-low, on i_reset_n. All state updates on posedge i_clk.
- Reset (i_reset_n=0 sampled): state=IDLE, cnt=0, o_period=0, o_valid=0, o_locked=0, o_timeout=0, match_cnt=0, prev=0. Reset overrides i_strobe in the same cycle. Initial values equal reset values.
- cnt is PW bits wide: cleared on a strobe, incremented otherwise in MEASURE.
- Measured period is cnt+1. Back-to-back strobes give 1; strobes every N cycles give N.
- State machine:
  - IDLE: cnt held at 0. A strobe moves to MEASURE with cnt=0; no o_valid.
  - MEASURE, strobe: o_period<=cnt+1 and o_valid<=1 (registered, visible the cycle after the strobe is sampled). Lock logic updates. Stay in MEASURE. o_timeout<=0.
  - MEASURE, no strobe, cnt==MAX_PERIOD-1: go to IDLE. o_timeout<=1, o_locked<=0, match_cnt<=0, cnt<=0. o_period keeps its value.
  - MEASURE, no strobe, otherwise: cnt<=cnt+1.
- Simultaneous strobe and cnt==MAX_PERIOD-1: strobe wins. Period = MAX_PERIOD is valid; no timeout.
- Strobe in IDLE while o_timeout=1: o_timeout<=0, enter MEASURE. The next period is the first measurement again.
- Lock, evaluated on every measurement except the first after IDLE:
  - Match when |cnt+1 - prev| <= TOL. Use unsigned compare of both differences; no wrap.
  - Match: match_cnt saturates at LOCK_COUNT-1.
  - Mismatch: match_cnt<=0 and o_locked<=0 in the same registered update as o_valid.
  - o_locked<=1 when match_cnt reaches LOCK_COUNT-1, in the same cycle as that o_valid.
  - prev<=cnt+1 on every measurement.
- o_valid is 0 in every cycle other than those stated above.

Optional Feature:
- Macro: STROBE_METER_STATS_EN.
- Defined: adds outputs o_min_period and o_max_period (PW each), plus an input i_stats_clr (1).
  - Both update on every o_valid measurement.
  - Reset and i_stats_clr=1 set min to all ones and max to 0.
  - When clear and a measurement coincide, the clear wins and the measurement is dropped.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- strobe_meter_pkg: state enum (IDLE, MEASURE) and a function computing PW from MAX_PERIOD.
- One sub-module, strobe_meter_lock: inputs are the measurement pulse, period and a clear; output is locked. It holds prev and match_cnt.
- Top level keeps the counter, FSM and timeout logic.

Test Plan:
- Reset hold: i_reset_n=0 for 5 cycles with i_strobe toggling -> all outputs 0, no o_valid.
- Strobe every 10 cycles (MAX_PERIOD=1024, LOCK_COUNT=4):
  - first strobe -> no o_valid;
  - second strobe -> o_valid one cycle later, o_period=10;
  - fourth measurement -> o_locked=1 in the same cycle as its o_valid.
- Locked at 10, one period of 11 (TOL=0) -> o_locked drops with that o_valid. Re-locks after 3 further matching 11s (4 consecutive matches).
- Strobes stop with MAX_PERIOD=16:
  - o_timeout=1 exactly 16 cycles after the last strobe, o_locked=0, o_period unchanged.
  - Next strobe -> o_timeout=0, no o_valid.
  - Strobe arriving exactly at cnt==15 -> o_period=16, no timeout.
- Constant i_strobe=1 -> o_valid every cycle with o_period=1. o_locked=1 after 4 measurements.
- Drop i_reset_n mid-measurement while locked -> all outputs 0 the next cycle. The first strobe afterwards produces no o_valid.
